pipeline_stall_ctrl: RTL and testbench
======================================

Name: pipeline_stall_ctrl

Overview:
- Central pipeline sequencer for the 5-stage core. Sits between the hazard unit and the pipeline registers.
- Merges hazard-unit stall/flush requests with instruction-memory and data-memory ready handshakes and a multi-cycle mult/div busy window.
- Drives per-stage enable and flush (bubble) signals. Detects data-memory timeout and latches a sticky bus error.

Parameters:
MD_LATENCY, 32, cycles a mult/div occupies HI/LO after leaving E (1..255)
MEM_TIMEOUT, 16, max consecutive data-memory wait cycles before error (2..255)

Ports:
clk  input  1  core clock, rising edge
rst  input  1  asynchronous active-high reset
hazStall  input  1  stallF/stallD request from hazard unit
hazFlushE  input  1  flushE request from hazard unit
imemReady  input  1  instruction word valid this cycle
memAccessM  input  1  M-stage load/store present
dmemReady  input  1  data memory completes M access this cycle
mdStartE  input  1  mult/div instruction in E
mdReadE  input  1  mfhi/mflo in E
imemReq  output  1  fetch request
dmemReq  output  1  data access request
enF, enD, enE, enM, enW  output  1 each  pipeline register load enables
flushD, flushE, flushM, flushW  output  1 each  load bubble into that stage register
mdBusy  output  1  mult/div counter nonzero
busErr  output  1  sticky data-memory timeout

Behaviour:
- Reset: state RUN; mdCnt=0; waitCnt=0.
- While rst=1, all outputs are 0.
- FSM states: RUN, DWAIT, ERR (2-bit encoding).
- Derived terms:
  - freezeM = memAccessM & !dmemReady
  - mdWait = (mdReadE | mdStartE) & (mdCnt!=0)
  - fetchWait = !imemReady
- Out of reset: imemReq=1; dmemReq=memAccessM in RUN/DWAIT, 0 in ERR.
- Output priority (combinational, first match wins; enables not listed are 1, flushes not listed are 0):
  1. state ERR: all en*=0, all flush*=0.
  2. freezeM: enF=enD=enE=enM=0, flushW=1.
  3. mdWait: enF=enD=enE=0, flushM=1.
  4. hazStall: enF=enD=0, flushE=1.
  5. fetchWait: enF=0, flushD=1, flushE=hazFlushE.
  6. otherwise: flushE=hazFlushE.
- A flush overrides its stage's enable to load a bubble; the flushed stage register is always clocked.
- Transitions:
  - RUN->DWAIT when freezeM; waitCnt<=1.
  - DWAIT->RUN when dmemReady; waitCnt<=0.
  - DWAIT, !dmemReady: waitCnt increments. When waitCnt==MEM_TIMEOUT-1, go to ERR and set busErr.
  - ERR holds until rst.
- mdCnt (8-bit):
  - Loads MD_LATENCY when mdStartE & enM & !freezeM & !mdWait & state!=ERR, i.e. the mult/div actually leaves E.
  - Otherwise decrements by 1 while nonzero, independent of freezes.
  - Saturates at 0. mdBusy = (mdCnt!=0).
- Simultaneous freezeM and hazStall: freezeM wins; hazard resolution is retried next cycle with unchanged pipeline contents.
- dmemReady arriving in the same cycle memAccessM rises: no wait, stays RUN.
- Reset mid-wait or mid-mult/div: aborts immediately. Counters clear; busErr clears.

Optional Feature:
- Macro: PIPE_PERF_CNT_EN.
- Defined: adds outputs stallCnt[31:0] and dmemWaitCnt[31:0].
  - stallCnt counts cycles with enF=0 out of reset.
  - dmemWaitCnt counts freezeM cycles.
  - Both reset to 0, wrap at 2^32, and freeze in ERR.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Load in M, dmemReady low 3 cycles then high -> enF..enM=0 and flushW=1 for 3 cycles; state DWAIT then RUN; no busErr.
- dmemReady held low with MEM_TIMEOUT=16 -> busErr=1 at 16th wait cycle; all en*=0 thereafter until rst; rst clears busErr=0.
- mult leaves E (MD_LATENCY=32), mfhi reaches E 2 cycles later -> enF=enD=enE=0, flushM=1 for 30 cycles; released when mdBusy falls.
- hazStall=1 with hazFlushE=1, memories ready -> enF=enD=0, flushE=1, enM=enW=1 for 1 cycle.
- imemReady=0 for 2 cycles, no other hazards -> enF=0, flushD=1 for 2 cycles; E/M/W keep advancing.
- freezeM and hazStall together -> only freeze response; hazStall response in the cycle after dmemReady.

Source files
------------

// File: rtl/pipeline_stall_ctrl_if.sv
// ============================================================================
// pipeline_stall_ctrl_if : hazard/memory handshake and stage-control bundle
//   for the pipeline sequencer. Optional counters under PIPE_PERF_CNT_EN.
// Rev 1.0
// ============================================================================
`default_nettype none

interface pipeline_stall_ctrl_if;
    logic hazStall;
    logic hazFlushE;
    logic imemReady;
    logic memAccessM;
    logic dmemReady;
    logic mdStartE;
    logic mdReadE;

    logic imemReq;
    logic dmemReq;
    logic enF, enD, enE, enM, enW;
    logic flushD, flushE, flushM, flushW;
    logic mdBusy;
    logic busErr;
`ifdef PIPE_PERF_CNT_EN
    logic [31:0] stallCnt;
    logic [31:0] dmemWaitCnt;
`endif

    // Hazard unit / memories side
    modport master (
        output hazStall, hazFlushE, imemReady, memAccessM, dmemReady, mdStartE, mdReadE,
        input  imemReq, dmemReq, enF, enD, enE, enM, enW,
        input  flushD, flushE, flushM, flushW, mdBusy, busErr
`ifdef PIPE_PERF_CNT_EN
        , input stallCnt, dmemWaitCnt
`endif
    );

    // Sequencer side
    modport slave (
        input  hazStall, hazFlushE, imemReady, memAccessM, dmemReady, mdStartE, mdReadE,
        output imemReq, dmemReq, enF, enD, enE, enM, enW,
        output flushD, flushE, flushM, flushW, mdBusy, busErr
`ifdef PIPE_PERF_CNT_EN
        , output stallCnt, dmemWaitCnt
`endif
    );
endinterface

`default_nettype wire

// File: rtl/pipeline_stall_ctrl.sv
// ============================================================================
// pipeline_stall_ctrl : 5-stage pipeline sequencer merging hazard, memory and
//   mult/div waits into stage enables/flushes. Optional PIPE_PERF_CNT_EN.
// Rev 1.0
// ============================================================================
`default_nettype none

module pipeline_stall_ctrl #(
    parameter int unsigned MD_LATENCY  = 32,
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    pipeline_stall_ctrl_if.slave  pif
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DWAIT = 2'd1,
        ERR   = 2'd2
    } state_t;

    localparam logic [7:0] MD_LAT8  = 8'(MD_LATENCY);
    localparam logic [7:0] TO_LAST8 = 8'(MEM_TIMEOUT - 1);

    state_t     state_q, state_d;
    logic [7:0] waitCnt_q, waitCnt_d;
    logic [7:0] mdCnt_q, mdCnt_d;
    logic       busErr_q, busErr_d;

    logic freezeM, mdWait, fetchWait, inErr, mdLoad;
    logic enF, enD, enE, enM, enW;
    logic flushD, flushE, flushM, flushW;

    assign freezeM   = pif.memAccessM & ~pif.dmemReady;
    assign mdWait    = (pif.mdReadE | pif.mdStartE) & (mdCnt_q != 8'd0);
    assign fetchWait = ~pif.imemReady;
    assign inErr     = (state_q == ERR);
    // The mult/div only occupies HI/LO once it really leaves E
    assign mdLoad    = pif.mdStartE & enM & ~freezeM & ~mdWait & ~inErr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= RUN;
            waitCnt_q <= 8'd0;
            mdCnt_q   <= 8'd0;
            busErr_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            waitCnt_q <= waitCnt_d;
            mdCnt_q   <= mdCnt_d;
            busErr_q  <= busErr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        waitCnt_d = waitCnt_q;
        busErr_d  = busErr_q;
        mdCnt_d   = mdCnt_q;
        enF = 1'b1; enD = 1'b1; enE = 1'b1; enM = 1'b1; enW = 1'b1;
        flushD = 1'b0; flushE = 1'b0; flushM = 1'b0; flushW = 1'b0;

        // Priority: error, data freeze, mult/div wait, hazard stall, fetch wait
        if (inErr) begin
            enF = 1'b0; enD = 1'b0; enE = 1'b0; enM = 1'b0; enW = 1'b0;
        end else if (freezeM) begin
            enF = 1'b0; enD = 1'b0; enE = 1'b0; enM = 1'b0;
            flushW = 1'b1;
        end else if (mdWait) begin
            enF = 1'b0; enD = 1'b0; enE = 1'b0;
            flushM = 1'b1;
        end else if (pif.hazStall) begin
            enF = 1'b0; enD = 1'b0;
            flushE = 1'b1;
        end else if (fetchWait) begin
            enF = 1'b0;
            flushD = 1'b1;
            flushE = pif.hazFlushE;
        end else begin
            flushE = pif.hazFlushE;
        end

        case (state_q)
            RUN: begin
                if (freezeM) begin
                    state_d   = DWAIT;
                    waitCnt_d = 8'd1;
                end
            end
            DWAIT: begin
                if (pif.dmemReady) begin
                    state_d   = RUN;
                    waitCnt_d = 8'd0;
                end else if (waitCnt_q == TO_LAST8) begin
                    state_d  = ERR;
                    busErr_d = 1'b1;
                end else begin
                    waitCnt_d = waitCnt_q + 8'd1;
                end
            end
            ERR:     state_d = ERR;
            default: state_d = RUN;
        endcase

        if (mdLoad) begin
            mdCnt_d = MD_LAT8;
        end else if (mdCnt_q != 8'd0) begin
            mdCnt_d = mdCnt_q - 8'd1;
        end
    end

    // All outputs are held low while reset is asserted
    assign pif.imemReq = ~rst;
    assign pif.dmemReq = ~rst & pif.memAccessM & ~inErr;
    assign pif.enF     = ~rst & enF;
    assign pif.enD     = ~rst & enD;
    assign pif.enE     = ~rst & enE;
    assign pif.enM     = ~rst & enM;
    assign pif.enW     = ~rst & enW;
    assign pif.flushD  = ~rst & flushD;
    assign pif.flushE  = ~rst & flushE;
    assign pif.flushM  = ~rst & flushM;
    assign pif.flushW  = ~rst & flushW;
    assign pif.mdBusy  = ~rst & (mdCnt_q != 8'd0);
    assign pif.busErr  = ~rst & busErr_q;

`ifdef PIPE_PERF_CNT_EN
    logic [31:0] stallCnt_q;
    logic [31:0] dmemWaitCnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stallCnt_q    <= 32'd0;
            dmemWaitCnt_q <= 32'd0;
        end else if (!inErr) begin
            if (!enF) begin
                stallCnt_q <= stallCnt_q + 32'd1;
            end
            if (freezeM) begin
                dmemWaitCnt_q <= dmemWaitCnt_q + 32'd1;
            end
        end
    end

    assign pif.stallCnt    = stallCnt_q;
    assign pif.dmemWaitCnt = dmemWaitCnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipeline_stall_ctrl.sv
// ============================================================================
// tb_pipeline_stall_ctrl : table-driven single-cycle vectors plus directed
//   multi-cycle sequences (memory wait, timeout, mult/div, fetch wait, reset).
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_pipeline_stall_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    pipeline_stall_ctrl_if pif();

    pipeline_stall_ctrl #(
        .MD_LATENCY  (32),
        .MEM_TIMEOUT (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .pif (pif)
    );

    always #5 clk = ~clk;

    logic [4:0]  en_v;
    logic [3:0]  fl_v;
    logic [14:0] all_v;
    assign en_v  = {pif.enF, pif.enD, pif.enE, pif.enM, pif.enW};
    assign fl_v  = {pif.flushD, pif.flushE, pif.flushM, pif.flushW};
    assign all_v = {en_v, fl_v, pif.imemReq, pif.dmemReq, pif.mdBusy, pif.busErr, 2'b00};

    // {hazStall, hazFlushE, imemReady, memAccessM, dmemReady, mdStartE, mdReadE}
    typedef struct {
        logic [6:0] in;
        logic [4:0] en;
        logic [3:0] fl;
        logic       dreq;
    } vec_t;

    vec_t vt[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic setin(input logic [6:0] v);
        pif.hazStall   = v[6];
        pif.hazFlushE  = v[5];
        pif.imemReady  = v[4];
        pif.memAccessM = v[3];
        pif.dmemReady  = v[2];
        pif.mdStartE   = v[1];
        pif.mdReadE    = v[0];
    endtask

    task automatic chk_pipe(input string name, input logic [4:0] en, input logic [3:0] fl);
        chk({name, ".en"}, 32'(en_v), 32'(en));
        chk({name, ".flush"}, 32'(fl_v), 32'(fl));
    endtask

    localparam logic [6:0] IDLE = 7'b0010000;

    initial begin
        vt[0]  = '{7'b0010000, 5'b11111, 4'b0000, 1'b0};
        vt[1]  = '{7'b0110000, 5'b11111, 4'b0100, 1'b0};
        vt[2]  = '{7'b1110000, 5'b00111, 4'b0100, 1'b0};
        vt[3]  = '{7'b1010000, 5'b00111, 4'b0100, 1'b0};
        vt[4]  = '{7'b0000000, 5'b01111, 4'b1000, 1'b0};
        vt[5]  = '{7'b0100000, 5'b01111, 4'b1100, 1'b0};
        vt[6]  = '{7'b0011100, 5'b11111, 4'b0000, 1'b1};
        vt[7]  = '{7'b0011000, 5'b00001, 4'b0001, 1'b1};
        vt[8]  = '{7'b1101000, 5'b00001, 4'b0001, 1'b1};
        vt[9]  = '{7'b0010001, 5'b11111, 4'b0000, 1'b0};
        vt[10] = '{7'b0010010, 5'b11111, 4'b0000, 1'b0};
        vt[11] = '{7'b1000000, 5'b00111, 4'b0100, 1'b0};

        // Reset: everything low even with active requests
        setin(7'b1101011);
        #3;
        chk("reset_outputs", 32'(all_v), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        setin(IDLE);
        #1;
        chk_pipe("post_reset", 5'b11111, 4'b0000);
        chk("post_reset.imemReq", 32'(pif.imemReq), 32'd1);
        chk("post_reset.mdBusy", 32'(pif.mdBusy), 32'd0);

        // Single-cycle vectors; idle restored before the clock edge
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            setin(vt[i].in);
            #1;
            chk_pipe($sformatf("vec%0d", i), vt[i].en, vt[i].fl);
            chk($sformatf("vec%0d.dmemReq", i), 32'(pif.dmemReq), 32'(vt[i].dreq));
            #1;
            setin(IDLE);
        end
        @(negedge clk);
        #1;
        chk("vec_state_untouched.mdBusy", 32'(pif.mdBusy), 32'd0);

        // Load waits 3 cycles with a hazard stall pending, then completes
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            setin(7'b1011000);
            #1;
            chk_pipe($sformatf("dwait%0d", k), 5'b00001, 4'b0001);
        end
        @(negedge clk);
        setin(7'b1011100);
        #1;
        chk_pipe("dwait_release_hazstall", 5'b00111, 4'b0100);
        @(negedge clk);
        setin(IDLE);
        #1;
        chk_pipe("dwait_after", 5'b11111, 4'b0000);
        chk("dwait_after.busErr", 32'(pif.busErr), 32'd0);

        // dmemReady together with the access: no wait
        @(negedge clk);
        setin(7'b0011100);
        #1;
        chk_pipe("mem_immediate", 5'b11111, 4'b0000);
        @(negedge clk);
        setin(IDLE);
        #1;
        chk_pipe("mem_immediate_next", 5'b11111, 4'b0000);

        // Timeout: 16 wait cycles then ERR
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            setin(7'b0011000);
            #1;
            chk_pipe($sformatf("timeout_wait%0d", k), 5'b00001, 4'b0001);
            if (k < 16) chk($sformatf("timeout_wait%0d.busErr", k), 32'(pif.busErr), 32'd0);
        end
        @(negedge clk);
        #1;
        chk("timeout.busErr", 32'(pif.busErr), 32'd1);
        chk_pipe("timeout.err", 5'b00000, 4'b0000);
        chk("timeout.dmemReq", 32'(pif.dmemReq), 32'd0);
        @(negedge clk);
        setin(7'b1111100);
        #1;
        chk_pipe("err_hold", 5'b00000, 4'b0000);
        chk("err_hold.busErr", 32'(pif.busErr), 32'd1);
        rst = 1'b1;
        #1;
        chk("err_reset.busErr", 32'(pif.busErr), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        setin(IDLE);
        #1;
        chk_pipe("err_after_reset", 5'b11111, 4'b0000);
        chk("err_after_reset.busErr", 32'(pif.busErr), 32'd0);

        // Mult leaves E, mfhi arrives two cycles later and waits out the counter
        @(negedge clk);
        setin(7'b0010010);
        #1;
        chk_pipe("mult_issue", 5'b11111, 4'b0000);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            setin(IDLE);
            #1;
            chk($sformatf("mult_busy%0d", k), 32'(pif.mdBusy), 32'd1);
        end
        begin
            int stall_cycles;
            int bad;
            stall_cycles = 0;
            bad = 0;
            for (int k = 0; k < 40; k++) begin
                @(negedge clk);
                setin(7'b0010001);
                #1;
                if (pif.enE) break;
                stall_cycles++;
                if (en_v !== 5'b00011 || fl_v !== 4'b0010) bad++;
            end
            chk("mfhi_stall_cycles", 32'(stall_cycles), 32'd30);
            chk("mfhi_stall_pattern_bad", 32'(bad), 32'd0);
            chk("mfhi_release.mdBusy", 32'(pif.mdBusy), 32'd0);
            chk_pipe("mfhi_release", 5'b11111, 4'b0000);
        end

        // Fetch wait two cycles
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            setin(7'b0000000);
            #1;
            chk_pipe($sformatf("fetch_wait%0d", k), 5'b01111, 4'b1000);
        end
        @(negedge clk);
        setin(IDLE);
        #1;
        chk_pipe("fetch_resume", 5'b11111, 4'b0000);

        // Reset in the middle of a mult/div window
        @(negedge clk);
        setin(7'b0010010);
        @(negedge clk);
        setin(IDLE);
        #1;
        chk("md_abort.before", 32'(pif.mdBusy), 32'd1);
        rst = 1'b1;
        #1;
        chk("md_abort.during", 32'(all_v), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("md_abort.after", 32'(pif.mdBusy), 32'd0);
        @(negedge clk);
        setin(7'b0010001);
        #1;
        chk_pipe("md_abort.mfhi_free", 5'b11111, 4'b0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
